// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the pipeline hazard controller:
// FSM state encoding, the zero register and the load-use decode.
package hazard_control_unit_pkg;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT     = 2'd2;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef enum logic [1:0] {
        S_RUN      = ST_RUN,
        S_MEM_WAIT = ST_MEM_WAIT,
        S_HALT     = ST_HALT
    } state_t;

    function automatic logic load_use(
        input logic       ex_memread,
        input logic [4:0] ex_rd,
        input logic       uses_rs1,
        input logic [4:0] rs1,
        input logic       uses_rs2,
        input logic [4:0] rs2
    );
        return ex_memread && (ex_rd != REG_X0) &&
               ((uses_rs1 && (rs1 == ex_rd)) ||
                (uses_rs2 && (rs2 == ex_rd)));
    endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline-side view of the hazard controller: hazard inputs,
// per-stage enables/flushes, watchdog flag and perf counters.
interface hazard_control_unit_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [4:0]       ex_rd;
    logic             ex_memread;
    logic             ex_redirect;
    logic             dmem_req;
    logic             dmem_ready;
    logic             pc_we;
    logic             if_id_we;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_we;
    logic             mem_wb_we;
    logic             halted;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_rd, ex_memread, ex_redirect,
        output dmem_req, dmem_ready,
        input  pc_we, if_id_we, if_id_flush, id_ex_flush,
        input  ex_mem_we, mem_wb_we,
        input  halted, stall_count, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_rd, ex_memread, ex_redirect,
        input  dmem_req, dmem_ready,
        output pc_we, if_id_we, if_id_flush, id_ex_flush,
        output ex_mem_we, mem_wb_we,
        output halted, stall_count, flush_count
    );

endinterface

// File: rtl/hazard_control_unit_sat.sv
// Saturating up-counter with synchronous clear, used for
// the stall and flush performance counters.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         en_i,
    input  logic         clear_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign q_o = cnt_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller: load-use bubbles, redirect
// flushes, dmem wait freezes with a timeout watchdog.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input logic            clk,
    input logic            rst_n,
    hazard_control_unit_if.slave hz
);

    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(MEM_TIMEOUT);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] wait_q;
    logic [CNT_W-1:0] wait_d;
    logic             halted_q;
    logic             halted_d;

    logic lu;
    logic ms;
    logic run_eval;
    logic freeze;
    logic flush_inc;

    assign lu = load_use(hz.ex_memread, hz.ex_rd,
                         hz.id_uses_rs1, hz.id_rs1,
                         hz.id_uses_rs2, hz.id_rs2);
    assign ms = hz.dmem_req && !hz.dmem_ready;

    always_comb begin
        state_d        = state_q;
        wait_d         = wait_q;
        halted_d       = halted_q;
        run_eval       = 1'b0;
        freeze         = 1'b0;
        flush_inc      = 1'b0;
        hz.pc_we       = 1'b1;
        hz.if_id_we    = 1'b1;
        hz.if_id_flush = 1'b0;
        hz.id_ex_flush = 1'b0;
        hz.ex_mem_we   = 1'b1;
        hz.mem_wb_we   = 1'b1;

        if (rst_n) begin
            unique case (state_q)
                S_RUN: run_eval = 1'b1;
                S_MEM_WAIT: begin
                    if (hz.dmem_ready) begin
                        run_eval = 1'b1;
                        state_d  = S_RUN;
                        wait_d   = '0;
                    end else begin
                        freeze = 1'b1;
                        wait_d = wait_q + 1'b1;
                        if (wait_q == TIMEOUT) begin
                            state_d  = S_HALT;
                            halted_d = 1'b1;
                        end
                    end
                end
                S_HALT: freeze = 1'b1;
                default: begin
                    freeze  = 1'b1;
                    state_d = S_RUN;
                end
            endcase

            // On a wait release ms is 0, so the stay-in-RUN path is taken
            if (run_eval) begin
                if (ms) begin
                    freeze  = 1'b1;
                    state_d = S_MEM_WAIT;
                    wait_d  = CNT_W'(1);
                end else if (hz.ex_redirect) begin
                    hz.if_id_flush = 1'b1;
                    hz.id_ex_flush = 1'b1;
                    flush_inc      = 1'b1;
                end else if (lu) begin
                    hz.pc_we       = 1'b0;
                    hz.if_id_we    = 1'b0;
                    hz.id_ex_flush = 1'b1;
                end
            end

            if (freeze) begin
                hz.pc_we     = 1'b0;
                hz.if_id_we  = 1'b0;
                hz.ex_mem_we = 1'b0;
                hz.mem_wb_we = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_RUN;
            wait_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            halted_q <= halted_d;
        end
    end

    assign hz.halted = halted_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .en_i    (!hz.pc_we),
        .clear_i (!rst_n),
        .q_o     (hz.stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .en_i    (flush_inc),
        .clear_i (!rst_n),
        .q_o     (hz.flush_count)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit with a per-cycle
// behavioural model and hand-computed spot checks.
module tb_hazard_control_unit;

    localparam int CW   = 3;
    localparam int TO   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_control_unit_if #(.CNT_W(CW)) hz ();

    hazard_control_unit #(
        .CNT_W       (CW),
        .MEM_TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    // Model state: mode 0=running, 1=waiting on dmem, 2=halted
    int m_mode   = 0;
    int m_wait   = 0;
    int m_halted = 0;
    int m_stall  = 0;
    int m_flush  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        hz.id_rs1      = 5'd0;
        hz.id_rs2      = 5'd0;
        hz.id_uses_rs1 = 1'b0;
        hz.id_uses_rs2 = 1'b0;
        hz.ex_rd       = 5'd0;
        hz.ex_memread  = 1'b0;
        hz.ex_redirect = 1'b0;
        hz.dmem_req    = 1'b0;
        hz.dmem_ready  = 1'b0;
    endtask

    task automatic set_lu();
        hz.ex_memread  = 1'b1;
        hz.ex_rd       = 5'd5;
        hz.id_rs2      = 5'd5;
        hz.id_uses_rs2 = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    always @(negedge clk) begin
        bit lu, ms, frz;
        bit e_pc, e_ifwe, e_iff, e_idf, e_exwe, e_mwwe;
        if (started) begin
            lu = hz.ex_memread && hz.ex_rd != 0 &&
                 ((hz.id_uses_rs1 && hz.id_rs1 == hz.ex_rd) ||
                  (hz.id_uses_rs2 && hz.id_rs2 == hz.ex_rd));
            ms = hz.dmem_req && !hz.dmem_ready;
            frz = 0;
            e_pc = 1; e_ifwe = 1; e_exwe = 1; e_mwwe = 1;
            e_iff = 0; e_idf = 0;
            if (!rst_n) begin
                frz = 0;
            end else if (m_mode == 2) begin
                frz = 1;
            end else if (m_mode == 1 && !hz.dmem_ready) begin
                frz = 1;
            end else if (m_mode == 0 && ms) begin
                frz = 1;
            end else if (hz.ex_redirect) begin
                e_iff = 1; e_idf = 1;
            end else if (lu) begin
                e_pc = 0; e_ifwe = 0; e_idf = 1;
            end
            if (frz) begin
                e_pc = 0; e_ifwe = 0; e_exwe = 0; e_mwwe = 0;
            end

            chk("cyc_pc_we", hz.pc_we, e_pc);
            chk("cyc_if_id_we", hz.if_id_we, e_ifwe);
            chk("cyc_if_id_flush", hz.if_id_flush, e_iff);
            chk("cyc_id_ex_flush", hz.id_ex_flush, e_idf);
            chk("cyc_ex_mem_we", hz.ex_mem_we, e_exwe);
            chk("cyc_mem_wb_we", hz.mem_wb_we, e_mwwe);
            chk("cyc_halted", hz.halted, m_halted);
            chk("cyc_stall_count", hz.stall_count, m_stall);
            chk("cyc_flush_count", hz.flush_count, m_flush);

            if (!rst_n) begin
                m_mode = 0; m_wait = 0; m_halted = 0;
                m_stall = 0; m_flush = 0;
            end else begin
                if (!e_pc && m_stall < MAXC) m_stall++;
                if (e_iff && m_flush < MAXC) m_flush++;
                if (m_mode == 0) begin
                    if (ms) begin
                        m_mode = 1;
                        m_wait = 1;
                    end
                end else if (m_mode == 1) begin
                    if (hz.dmem_ready) begin
                        m_mode = 0;
                        m_wait = 0;
                    end else if (m_wait == TO) begin
                        m_mode = 2;
                        m_halted = 1;
                    end else begin
                        m_wait++;
                    end
                end
            end
        end
    end

    initial begin
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        started = 1'b1;
        #1;
        step();
        rst_n = 1'b1;
        #1;
        chk("rst_stall", hz.stall_count, 0);
        chk("rst_flush", hz.flush_count, 0);
        chk("rst_halted", hz.halted, 0);

        // load-use bubble
        set_lu();
        #1;
        chk("lu_pc_we", hz.pc_we, 0);
        chk("lu_if_id_we", hz.if_id_we, 0);
        chk("lu_id_ex_flush", hz.id_ex_flush, 1);
        chk("lu_ex_mem_we", hz.ex_mem_we, 1);
        step();
        idle();
        #1;
        chk("lu_stall_count", hz.stall_count, 1);
        chk("lu_after_pc_we", hz.pc_we, 1);

        // x0 destination and unused operands
        hz.ex_memread  = 1'b1;
        hz.ex_rd       = 5'd0;
        hz.id_rs1      = 5'd0;
        hz.id_uses_rs1 = 1'b1;
        #1;
        chk("x0_pc_we", hz.pc_we, 1);
        step();
        hz.ex_rd       = 5'd7;
        hz.id_rs1      = 5'd7;
        hz.id_rs2      = 5'd7;
        hz.id_uses_rs1 = 1'b0;
        hz.id_uses_rs2 = 1'b0;
        #1;
        chk("unused_pc_we", hz.pc_we, 1);
        chk("unused_if_id_we", hz.if_id_we, 1);
        step();
        idle();
        #1;
        chk("unused_stall_count", hz.stall_count, 1);

        // redirect overrides load-use
        do_reset();
        set_lu();
        hz.ex_redirect = 1'b1;
        #1;
        chk("rdr_pc_we", hz.pc_we, 1);
        chk("rdr_if_id_flush", hz.if_id_flush, 1);
        chk("rdr_id_ex_flush", hz.id_ex_flush, 1);
        step();
        idle();
        #1;
        chk("rdr_flush_count", hz.flush_count, 1);
        chk("rdr_stall_count", hz.stall_count, 0);

        // dmem ignored without request
        hz.dmem_ready = 1'b1;
        #1;
        chk("rdy_noreq_pc_we", hz.pc_we, 1);
        step();

        // three-cycle memory wait, redirect pending across it
        do_reset();
        hz.dmem_req    = 1'b1;
        hz.ex_redirect = 1'b1;
        #1;
        chk("mw_c1_pc_we", hz.pc_we, 0);
        chk("mw_c1_flush", hz.if_id_flush, 0);
        step();
        chk("mw_c2_mem_wb_we", hz.mem_wb_we, 0);
        step();
        chk("mw_c3_ex_mem_we", hz.ex_mem_we, 0);
        step();
        hz.dmem_ready = 1'b1;
        #1;
        chk("mw_rel_pc_we", hz.pc_we, 1);
        chk("mw_rel_mem_wb_we", hz.mem_wb_we, 1);
        chk("mw_rel_if_id_flush", hz.if_id_flush, 1);
        step();
        idle();
        #1;
        chk("mw_stall_count", hz.stall_count, 3);
        chk("mw_flush_count", hz.flush_count, 1);
        chk("mw_run_pc_we", hz.pc_we, 1);

        // watchdog timeout
        do_reset();
        hz.dmem_req = 1'b1;
        repeat (4) step();
        chk("to_not_yet", hz.halted, 0);
        step();
        chk("to_halted", hz.halted, 1);
        hz.dmem_ready = 1'b1;
        #1;
        chk("to_halt_pc_we", hz.pc_we, 0);
        step();
        chk("to_sticky", hz.halted, 1);
        rst_n = 1'b0;
        #1;
        chk("to_rst_forced_we", hz.pc_we, 1);
        step();
        rst_n = 1'b1;
        idle();
        #1;
        chk("to_rst_halted", hz.halted, 0);
        chk("to_rst_stall", hz.stall_count, 0);
        chk("to_rst_pc_we", hz.pc_we, 1);

        // saturation of the stall counter
        set_lu();
        repeat (10) step();
        idle();
        #1;
        chk("sat_stall_count", hz.stall_count, 7);

        repeat (2) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
